// File: rtl/frame_writer_pkg.sv
// Shared types and widths for the SRAM frame writer.
package frame_writer_pkg;
  localparam int PIX_W  = 16;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    LAST  = 2'd3
  } wr_state_e;
endpackage

// File: rtl/word_fifo.sv
// Synchronous word FIFO, power-of-two depth, with a synchronous flush.
module word_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr, rptr;
  logic             do_push, do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rdata   = mem[rptr[AW-1:0]];
  // A pop frees the head slot in the same edge, so push into a full FIFO is fine then.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else if (clr) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/sram_frame_writer.sv
// Packs 16-bit pixel pairs into 32-bit words, queues them, and feeds the
// SRAM controller one word at a time while counting words in the frame.
module sram_frame_writer
  import frame_writer_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int FRAME_WORDS = 38400,
  parameter int ADDR_W      = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic [ADDR_W-1:0] frame_base,
  input  logic              pix_valid,
  input  logic [PIX_W-1:0]  pix_data,
  output logic              sram_start_write,
  output logic              sram_wren,
  output logic [WORD_W-1:0] sram_data_write,
  output logic [ADDR_W-1:0] sram_starting_address,
  output logic              sram_counter_done,
  input  logic              sram_done,
  output logic              busy,
  output logic              frame_done,
  output logic              overflow,
  output logic [15:0]       words_written
);
  localparam logic [15:0] FW = 16'(FRAME_WORDS);

  wr_state_e         state, state_nxt;
  logic              half;
  logic [PIX_W-1:0]  held;
  logic [15:0]       pack_cnt;
  logic              start_ok, pix_take, push, pop;
  logic              fifo_full, fifo_empty;
  logic [WORD_W-1:0] fifo_head;

  assign start_ok = frame_start & ~busy;
  // Packing stops once a full frame's worth of words has been queued.
  assign pix_take = busy & pix_valid & (pack_cnt != FW);
  assign push     = pix_take & half;
  assign pop      = (state == WAIT) & sram_done;

  word_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(WORD_W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clr   (state == LAST),
    .push  (push),
    .wdata ({held, pix_data}),
    .pop   (pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!fifo_empty) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (sram_done) state_nxt = (words_written + 16'd1 == FW) ? LAST : IDLE;
      LAST:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy                  <= 1'b0;
      overflow              <= 1'b0;
      half                  <= 1'b0;
      held                  <= '0;
      pack_cnt              <= '0;
      words_written         <= '0;
      sram_starting_address <= '0;
    end else if (start_ok) begin
      busy                  <= 1'b1;
      overflow              <= 1'b0;
      half                  <= 1'b0;
      pack_cnt              <= '0;
      words_written         <= '0;
      sram_starting_address <= frame_base;
    end else begin
      if (pix_take) begin
        half <= ~half;
        if (!half) held <= pix_data;
      end
      // Dropped words do not advance the pack count, so the frame can still complete.
      if (push && fifo_full && !pop) overflow <= 1'b1;
      else if (push)                 pack_cnt <= pack_cnt + 16'd1;
      if (pop)                       words_written <= words_written + 16'd1;
      if (state == LAST)             busy <= 1'b0;
    end
  end

  assign sram_start_write  = (state == ISSUE);
  assign sram_wren         = (state == ISSUE) || (state == WAIT);
  assign sram_data_write   = sram_wren ? fifo_head : '0;
  assign sram_counter_done = sram_wren && (words_written == FW - 16'd1);
  assign frame_done        = (state == LAST);
endmodule

// File: tb/tb_sram_frame_writer.sv
// Directed bench for sram_frame_writer: pack/issue, frame end, overflow, ignores, reset.
module tb_sram_frame_writer;
  localparam int FIFO_DEPTH  = 4;
  localparam int FRAME_WORDS = 6;
  localparam int ADDR_W      = 18;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              frame_start = 1'b0;
  logic [ADDR_W-1:0] frame_base = '0;
  logic              pix_valid = 1'b0;
  logic [15:0]       pix_data = '0;
  logic              sram_done = 1'b0;
  logic              sram_start_write, sram_wren, sram_counter_done;
  logic              busy, frame_done, overflow;
  logic [31:0]       sram_data_write;
  logic [ADDR_W-1:0] sram_starting_address;
  logic [15:0]       words_written;

  int n_tests = 0;
  int n_fail  = 0;
  int sw_cnt  = 0;
  int exp_ww  = 0;

  sram_frame_writer #(
    .FIFO_DEPTH(FIFO_DEPTH), .FRAME_WORDS(FRAME_WORDS), .ADDR_W(ADDR_W)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .frame_start           (frame_start),
    .frame_base            (frame_base),
    .pix_valid             (pix_valid),
    .pix_data              (pix_data),
    .sram_start_write      (sram_start_write),
    .sram_wren             (sram_wren),
    .sram_data_write       (sram_data_write),
    .sram_starting_address (sram_starting_address),
    .sram_counter_done     (sram_counter_done),
    .sram_done             (sram_done),
    .busy                  (busy),
    .frame_done            (frame_done),
    .overflow              (overflow),
    .words_written         (words_written)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (sram_start_write) sw_cnt <= sw_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_pix(input logic [15:0] d);
    pix_valid = 1'b1;
    pix_data  = d;
    tick;
    pix_valid = 1'b0;
  endtask

  task automatic wait_issue(output int n);
    n = 0;
    while (!sram_start_write && n < 10) begin
      tick;
      n++;
    end
    chk("issue_seen", {31'd0, sram_start_write}, 32'd1);
  endtask

  // Two pixels in, one word out; sram_done two cycles after the request.
  task automatic do_word(input logic [15:0] a, input logic [15:0] b,
                         input logic exp_cd, output int lat);
    send_pix(a);
    send_pix(b);
    wait_issue(lat);
    chk("data", sram_data_write, {a, b});
    chk("cd_issue", {31'd0, sram_counter_done}, {31'd0, exp_cd});
    tick;
    chk("start_one_cycle", {31'd0, sram_start_write}, 32'd0);
    chk("cd_wait", {31'd0, sram_counter_done}, {31'd0, exp_cd});
    chk("wren_wait", {31'd0, sram_wren}, 32'd1);
    tick;
    sram_done = 1'b1;
    tick;
    sram_done = 1'b0;
    exp_ww++;
    chk("words", {16'd0, words_written}, exp_ww);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int sw0;
    repeat (2) tick;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_wren", {31'd0, sram_wren}, 32'd0);
    chk("rst_addr", {14'd0, sram_starting_address}, 32'd0);
    chk("rst_words", {16'd0, words_written}, 32'd0);
    reset = 1'b1;
    tick;

    // Pixels with no frame armed are ignored.
    send_pix(16'h1111); send_pix(16'h2222); send_pix(16'h3333); send_pix(16'h4444);
    repeat (4) tick;
    chk("pre_frame_writes", sw_cnt, 32'd0);
    chk("pre_frame_busy", {31'd0, busy}, 32'd0);

    // Frame 1: pack/issue, ignored events, frame end.
    frame_base = 18'h00100; frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    exp_ww = 0;
    chk("f1_busy", {31'd0, busy}, 32'd1);
    chk("f1_addr", {14'd0, sram_starting_address}, 32'h00100);
    do_word(16'hAAAA, 16'h5555, 1'b0, lat);
    chk("latency", lat, 32'd1);

    frame_base = 18'h02222; frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    chk("start_while_busy", {14'd0, sram_starting_address}, 32'h00100);
    sram_done = 1'b1;
    tick;
    sram_done = 1'b0;
    tick;
    chk("done_in_idle", {16'd0, words_written}, 32'd1);
    chk("done_in_idle_wr", {31'd0, sram_wren}, 32'd0);

    for (int k = 1; k < 6; k++) begin
      do_word(16'h0100 + 16'(2*k), 16'h0101 + 16'(2*k), (k == 5), lat);
      if (k < 5) chk("early_frame_done", {31'd0, frame_done}, 32'd0);
    end
    chk("frame_done", {31'd0, frame_done}, 32'd1);
    tick;
    chk("frame_done_pulse", {31'd0, frame_done}, 32'd0);
    chk("f1_end_busy", {31'd0, busy}, 32'd0);
    chk("f1_end_words", {16'd0, words_written}, 32'd6);

    // Frame 2: overflow with sram_done held low.
    frame_base = 18'h3ABCD; frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    exp_ww = 0;
    sw0 = sw_cnt;
    for (int k = 0; k < 12; k++) send_pix(16'h1000 + 16'(k));
    tick;
    chk("ovf_flag", {31'd0, overflow}, 32'd1);
    chk("ovf_issued", sw_cnt - sw0, 32'd1);
    chk("ovf_data0", sram_data_write, 32'h10001001);
    chk("ovf_words", {16'd0, words_written}, 32'd0);
    sram_done = 1'b1;
    tick;
    sram_done = 1'b0;
    for (int j = 1; j < 4; j++) begin
      wait_issue(lat);
      chk("ovf_data", sram_data_write, {16'h1000 + 16'(2*j), 16'h1001 + 16'(2*j)});
      tick;
      sram_done = 1'b1;
      tick;
      sram_done = 1'b0;
    end
    chk("ovf_retired", {16'd0, words_written}, 32'd4);
    exp_ww = 4;
    do_word(16'h2000, 16'h2001, 1'b0, lat);
    do_word(16'h2002, 16'h2003, 1'b1, lat);
    chk("f2_frame_done", {31'd0, frame_done}, 32'd1);
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);
    tick;
    chk("f2_end_busy", {31'd0, busy}, 32'd0);

    // Frame 3: overflow cleared on acceptance, then reset mid-WAIT.
    frame_base = 18'h00040; frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    chk("ovf_cleared", {31'd0, overflow}, 32'd0);
    chk("f3_words", {16'd0, words_written}, 32'd0);
    chk("f3_addr", {14'd0, sram_starting_address}, 32'h00040);
    send_pix(16'hBEEF);
    send_pix(16'hCAFE);
    wait_issue(lat);
    tick;
    chk("pre_rst_wren", {31'd0, sram_wren}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("arst_wren", {31'd0, sram_wren}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_data", sram_data_write, 32'd0);
    chk("arst_addr", {14'd0, sram_starting_address}, 32'd0);
    chk("arst_cd", {31'd0, sram_counter_done}, 32'd0);
    tick;
    reset = 1'b1;
    sw0 = sw_cnt;
    repeat (5) tick;
    chk("post_rst_no_write", sw_cnt - sw0, 32'd0);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
